// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states and
// the datapath mux / ALU control codes that the datapath decodes identically.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R   = 6'd0;
  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_JAL = 6'd3;
  localparam logic [5:0] OP_LW  = 6'd4;
  localparam logic [5:0] OP_SW  = 6'd5;
  localparam logic [5:0] OP_BEQ = 6'd6;

  typedef logic [3:0] state_t;

  localparam state_t S_START    = 4'd0;
  localparam state_t S_FETCH    = 4'd1;
  localparam state_t S_DECODE   = 4'd2;
  localparam state_t S_EXEC_R   = 4'd3;
  localparam state_t S_WB_R     = 4'd4;
  localparam state_t S_MEM_ADDR = 4'd5;
  localparam state_t S_MEM_RD   = 4'd6;
  localparam state_t S_WB_MEM   = 4'd7;
  localparam state_t S_MEM_WR   = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;
  localparam state_t S_JUMP     = 4'd10;
  localparam state_t S_JAL      = 4'd11;
  localparam state_t S_TRAP     = 4'd12;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALU_B_RT      = 2'b00;
  localparam logic [1:0] ALU_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

endpackage

// File: rtl/ctrl_retire_counter.sv
// Retired-instruction counter: async clear, +1 per enable, wraps modulo 2^CNT_W.
module ctrl_retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multi-cycle MIPS datapath with a req/ready memory port.
//
// state    | meaning
// START    | post-reset idle, all outputs low
// FETCH    | read instruction at PC, PC <= PC + 4 on completion
// DECODE   | branch target into ALUOut, dispatch on opcode
// EXEC_R   | rs op rt via funct
// WB_R     | write ALUOut to rd
// MEM_ADDR | rs + imm into ALUOut
// MEM_RD   | load from ALUOut
// WB_MEM   | write MDR to rt
// MEM_WR   | store rt to ALUOut
// BRANCH   | compare rs/rt, take ALUOut on zero
// JUMP     | PC <= jump target
// JAL      | PC <= jump target, r31 <= PC
// TRAP     | unknown opcode, parked until reset
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             jal,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_START;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = ALU_B_RT;
    alu_op        = ALU_OP_ADD;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    jal           = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = ALU_B_FOUR;
        // IR and PC load only on the cycle the memory actually returns data
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = ALU_B_IMM_SH2;
        case (opcode)
          OP_R:         state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_WB_R;
      end
      S_WB_R: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PC_SRC_ALUOUT;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PC_SRC_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_src     = PC_SRC_JUMP;
        reg_write  = 1'b1;
        jal        = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: illegal = 1'b1;
      default: state_d = S_START;
    endcase
  end

  ctrl_retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire (
    .clk  (clk),
    .reset(reset),
    .inc  (instr_done),
    .count(instret)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction latency and strobe counts derived
// from opcode and memory wait counts, plus reset, trap and counter-wrap cases.
module tb_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0]       pc_src, alu_src_b, alu_op;
  logic             alu_src_a, reg_dst, mem_to_reg, reg_write, jal, instr_done, illegal;
  logic [CNT_W-1:0] instret;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;
  int wait_left = 0;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .jal(jal), .instr_done(instr_done), .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] outs();
    return {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
            alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
            jal, instr_done, illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: memory model drives mem_ready at the falling edge, outputs sampled 1ns later.
  task automatic step();
    @(negedge clk);
    if (mem_req) begin
      if (wait_left > 0) begin
        mem_ready = 1'b0;
        wait_left--;
      end else begin
        mem_ready = 1'b1;
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
    end
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf, input int wd, output int cyc);
    int nreq, nwe, nrw, nir, npw, npwc, njal, nrd, nm2r, njt, nbeq, nbad;
    bit done, ls;
    int base;
    nreq = 0; nwe = 0; nrw = 0; nir = 0; npw = 0; npwc = 0; njal = 0;
    nrd = 0; nm2r = 0; njt = 0; nbeq = 0; nbad = 0;
    done = 0; cyc = 0;
    opcode = op;
    wait_left = wf;
    while (!done && cyc < 40) begin
      step();
      cyc++;
      if (cyc == 1) begin
        chk($sformatf("instret_at_fetch op%0d", op), 32'(instret), 32'(model_cnt % 16));
        chk($sformatf("fetch_ctrl op%0d", op),
            32'({mem_req, iord, alu_src_a, alu_src_b, alu_op, pc_src}), 32'(9'b1_0_0_01_00_00));
      end
      nreq += int'(mem_req);
      nwe  += int'(mem_we);
      nrw  += int'(reg_write);
      nir  += int'(ir_write);
      npw  += int'(pc_write);
      npwc += int'(pc_write_cond);
      njal += int'(jal);
      nrd  += int'(reg_write && reg_dst);
      nm2r += int'(reg_write && mem_to_reg);
      njt  += int'(pc_write && pc_src == 2'b10);
      nbeq += int'(pc_write_cond && pc_src == 2'b01);
      nbad += int'(mem_we && !(mem_req && iord));
      if (mem_req && mem_ready && !iord) wait_left = wd;
      if (instr_done) done = 1;
    end
    chk($sformatf("retired op%0d", op), 32'(done), 32'd1);
    model_cnt++;
    ls   = (op == OP_LW) || (op == OP_SW);
    base = (op == OP_LW) ? 5 : ((op == OP_R || op == OP_SW) ? 4 : 3);
    chk($sformatf("latency op%0d", op), cyc, base + wf + (ls ? wd : 0));
    chk($sformatf("mem_req_cycles op%0d", op), nreq, 1 + wf + (ls ? 1 + wd : 0));
    chk($sformatf("mem_we_cycles op%0d", op), nwe, (op == OP_SW) ? 1 + wd : 0);
    chk($sformatf("reg_write_cycles op%0d", op), nrw, (op == OP_R || op == OP_LW || op == OP_JAL) ? 1 : 0);
    chk($sformatf("ir_write_cycles op%0d", op), nir, 1);
    chk($sformatf("pc_write_cycles op%0d", op), npw, (op == OP_J || op == OP_JAL) ? 2 : 1);
    chk($sformatf("pc_write_cond_cycles op%0d", op), npwc, (op == OP_BEQ) ? 1 : 0);
    chk($sformatf("jal_cycles op%0d", op), njal, (op == OP_JAL) ? 1 : 0);
    chk($sformatf("rd_write op%0d", op), nrd, (op == OP_R) ? 1 : 0);
    chk($sformatf("mdr_write op%0d", op), nm2r, (op == OP_LW) ? 1 : 0);
    chk($sformatf("jump_target op%0d", op), njt, (op == OP_J || op == OP_JAL) ? 1 : 0);
    chk($sformatf("beq_aluout op%0d", op), nbeq, (op == OP_BEQ) ? 1 : 0);
    chk($sformatf("we_without_data_req op%0d", op), nbad, 0);
  endtask

  initial begin
    logic [5:0] legal [6];
    int c, tot;
    bit found;
    legal[0] = OP_R; legal[1] = OP_J; legal[2] = OP_JAL;
    legal[3] = OP_LW; legal[4] = OP_SW; legal[5] = OP_BEQ;

    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = OP_R;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_instret", 32'(instret), 32'd0);
    reset = 1'b0;
    #1;
    chk("start_outs", 32'(outs()), 32'd0);

    run_instr(OP_R, 0, 0, c);
    run_instr(OP_LW, 0, 2, c);
    chk("lw_2wait_total", c, 7);

    tot = 0;
    run_instr(OP_SW, 0, 0, c);  tot += c;
    run_instr(OP_BEQ, 0, 0, c); tot += c;
    run_instr(OP_JAL, 0, 0, c); tot += c;
    chk("sw_beq_jal_total", tot, 10);

    for (int i = 0; i < 25; i++) begin
      run_instr(legal[$urandom_range(0, 5)], int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), c);
    end

    // Unknown opcode parks in TRAP with only illegal raised.
    opcode = 6'h3f;
    wait_left = 0;
    step();
    chk("trap_fetch_req", 32'(mem_req), 32'd1);
    step();
    chk("trap_decode_illegal", 32'(illegal), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("trap_outs", 32'(outs()), 32'd1);
    end
    chk("trap_instret", 32'(instret), 32'(model_cnt % 16));
    reset = 1'b1;
    #1;
    chk("trap_reset_illegal", 32'(illegal), 32'd0);
    model_cnt = 0;
    #2;
    reset = 1'b0;

    // Reset asserted mid data-read wait must drop mem_req without a clock edge.
    opcode = OP_LW;
    wait_left = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (mem_req && iord) found = 1;
      else if (mem_req && mem_ready) wait_left = 10;
    end
    chk("reached_mem_rd", 32'(found), 32'd1);
    chk("mem_rd_waiting", 32'(mem_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("async_reset_mem_req", 32'(mem_req), 32'd0);
    chk("async_reset_outs", 32'(outs()), 32'd0);
    chk("async_reset_instret", 32'(instret), 32'd0);
    #2;
    reset = 1'b0;

    for (int i = 0; i < 16; i++) run_instr(OP_J, 0, 0, c);
    step();
    chk("instret_wrap", 32'(instret), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
